alu_req_sched: RTL
==================

# alu_req_sched

Round-robin scheduler that shares one lane of the dual 8-bit ALU datapath among up to four requesters. It grants one operation at a time, drives the ALU operand/select inputs, waits the ALU's fixed latency, and returns the result, carry and originating requester ID on a valid/ready response port. It sits between the user-project requesters (IO-pad decoder, LA-driven test port, wishbone shim) and the ALU lane inside the user project wrapper.

## Interface
- NREQ, 4: number of requesters; legal values 2..4.
- WIDTH, 8: operand and result width.
- LAT, 1: ALU latency in cycles, from operands applied to result valid; must be ≥1.
- wb_clk_i  in  1  sole clock; all logic is on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_sel  in  2*NREQ  ALU select for requester i, at bits [2i+1:2i].
- req_a  in  WIDTH*NREQ  operand A for requester i, at slice i.
- req_b  in  WIDTH*NREQ  operand B for requester i, at slice i.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_sel  out  2  registered ALU select.
- alu_out  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry out.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_data  out  WIDTH  captured result.
- resp_carry  out  1  captured carry.
- resp_id  out  2  index of the requester that owns the response.
- busy  out  1  high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - If any req_valid is high, grant the first valid index searching upward (with wrap) from last_grant+1.
  - req_ready[g] goes high combinationally in the same cycle; that cycle is the handshake.
  - At the clock edge: latch req_a/req_b/req_sel slice g into alu_a/alu_b/alu_sel; set last_grant=g; set id_q=g; load cnt=LAT-1; move to WAIT.
  - If no req_valid is high, stay in IDLE and drive req_ready all zero.
- WAIT:
  - If cnt≠0, decrement cnt.
  - If cnt==0, capture alu_out/alu_carry into resp_data/resp_carry, copy id_q to resp_id, and move to RESP.
- RESP:
  - resp_valid is high.
  - Hold resp_data, resp_carry and resp_id stable until resp_ready is sampled high, then move to IDLE.
  - There is no grant in the same cycle as the response handshake.
- req_ready is zero in WAIT and RESP.
- Requesters must hold valid and payload stable until ready. Payload of non-granted requesters is ignored.
- alu_a, alu_b and alu_sel hold their last value until the next grant.
- Round-robin pointer:
  - last_grant resets to NREQ-1, so requester 0 has first priority after reset.
  - Wrap is modulo NREQ.
  - Indices ≥NREQ are never granted.
- Reset mid-operation: the in-flight op is dropped and no response is produced. The requester already got its handshake, so it is not re-issued.

## Timing
- Reset values:
  - FSM=IDLE, last_grant=NREQ-1, cnt=0, id_q=0.
  - alu_a=0, alu_b=0, alu_sel=0.
  - resp_valid=0, resp_data=0, resp_carry=0, resp_id=0.
  - req_ready=0, busy=0.
- With the grant in cycle T:
  - alu_* are valid from T+1.
  - resp_valid rises at T+LAT+1.
- With resp_ready held high:
  - The response handshake is at T+LAT+1.
  - IDLE is reached at T+LAT+2, where the next grant is possible.
  - Peak throughput is 1 op per LAT+2 cycles.
- Simultaneous events:
  - A req_valid that rises during WAIT or RESP waits for IDLE.
  - Arbitration uses req_valid as sampled in the IDLE cycle only.
- resp_ready held low stalls the FSM in RESP indefinitely with no data change.

## Configuration
- ALU_SCHED_STATS_EN defined:
  - Adds per-requester 16-bit grant counters, reset to 0, incremented on each handshake and saturating at 16'hFFFF.
  - Adds ports stat_idx (in, 2) and stat_cnt (out, 16).
  - stat_cnt is the combinational read of counter[stat_idx]; it reads 0 for stat_idx≥NREQ.
- ALU_SCHED_STATS_EN undefined:
  - The counters and the stat_idx/stat_cnt ports are absent.
  - All other behaviour is identical.

## Test plan
- Single op, LAT=1:
  - Stimulus: req_valid=4'b0001, a=8'h05, b=8'h03, sel=2'b00.
  - Required: req_ready[0] in cycle T; alu_a=8'h05, alu_b=8'h03 at T+1; resp_valid at T+2 with resp_id=0 and resp_data/resp_carry equal to the ALU model's output for that op.
- Fairness:
  - Stimulus: all four requesters held valid continuously.
  - Required: grant order 0,1,2,3,0; grants spaced 3 cycles apart with resp_ready tied high.
- Backpressure:
  - Stimulus: resp_ready low for 5 cycles in RESP.
  - Required: resp_data, resp_carry and resp_id stable; req_ready=0 throughout; next grant 1 cycle after the ready handshake.
- Latency parameter:
  - Stimulus: LAT=3, single op granted at T.
  - Required: resp_valid at exactly T+4; alu_* unchanged across the WAIT cycles.
- Reset mid-operation:
  - Stimulus: wb_rst_i asserted in WAIT.
  - Required: next cycle is IDLE with all outputs at reset values, no resp_valid, and requester 0 has priority again.
- Stats (ALU_SCHED_STATS_EN defined):
  - Stimulus: 65540 grants to requester 2.
  - Required: stat_idx=2 reads 16'hFFFF; stat_idx=3 reads 0.

Source files
------------

// File: rtl/alu_req_sched.sv
// alu_req_sched: round-robin scheduler sharing one ALU lane among NREQ requesters; ALU_SCHED_STATS_EN adds grant counters.
module alu_req_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_sel,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [1:0]            alu_sel,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_carry,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_carry,
    output logic [1:0]            resp_id,
    output logic                  busy
`ifdef ALU_SCHED_STATS_EN
    ,
    input  logic [1:0]            stat_idx,
    output logic [15:0]           stat_cnt
`endif
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_d;
    logic [1:0]    last_grant, grant, id_q, idx;
    logic          any;
    logic [CW-1:0] cnt;

    // Descending scan so the nearest valid index after last_grant wins.
    always_comb begin
        any = 1'b0;
        grant = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 2'((int'(last_grant) + k) % NREQ);
            if (req_valid[idx]) begin
                any = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        state_d = state == IDLE ? (any ? WAIT : IDLE)
                : state == WAIT ? (cnt == '0 ? RESP : WAIT)
                : (resp_ready ? IDLE : RESP);
        req_ready = (state == IDLE && any) ? NREQ'(1) << grant : '0;
        busy = state != IDLE;
        resp_valid = state == RESP;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last_grant <= 2'(NREQ - 1);
            cnt        <= '0;
            id_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
            resp_id    <= '0;
        end else begin
            if (state == IDLE && any) begin
                alu_a      <= req_a[grant*WIDTH +: WIDTH];
                alu_b      <= req_b[grant*WIDTH +: WIDTH];
                alu_sel    <= req_sel[grant*2 +: 2];
                last_grant <= grant;
                id_q       <= grant;
                cnt        <= CW'(LAT - 1);
            end
            if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0) begin
                resp_data  <= alu_out;
                resp_carry <= alu_carry;
                resp_id    <= id_q;
            end
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] gcnt [NREQ];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NREQ; i++)
                gcnt[i] <= '0;
        end else if (state == IDLE && any && gcnt[grant] != 16'hFFFF) begin
            gcnt[grant] <= gcnt[grant] + 16'd1;
        end
    end

    assign stat_cnt = (int'(stat_idx) < NREQ) ? gcnt[stat_idx] : '0;
`endif
endmodule
